// File: rtl/phase_sequencer.sv
// phase_sequencer: generates one-hot instruction phase strobes from clk.
// Each instruction has a variable phase count, latched from phase_limit when
// decode (phase 2) ends. The sequencer can be stalled or restarted, and it
// counts retired instructions.
// Optional build macro PHASE_SINGLE_STEP_EN: adds the step/halted ports and a
// STEP_WAIT state that parks the sequencer after each instruction.
//
// state     | meaning
// IDLE      | reset released, first edge enters phase 1
// RUN       | strobing phases 1..lim
// STEP_WAIT | instruction finished, waiting for step/restart (macro only)
module phase_sequencer #(
  parameter int NUM_PHASES = 12,
  parameter int CNT_W      = 4,
  parameter int ICNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef PHASE_SINGLE_STEP_EN
  input  logic                  step,
  output logic                  halted,
`endif
  input  logic                  stall,
  input  logic                  restart,
  input  logic [CNT_W-1:0]      phase_limit,
  output logic [NUM_PHASES-1:0] phase,
  output logic [CNT_W-1:0]      phase_idx,
  output logic                  instr_start,
  output logic                  instr_done,
  output logic [ICNT_W-1:0]     instr_count
);

  localparam logic [CNT_W-1:0] LIM_MAX   = CNT_W'(NUM_PHASES);
  localparam logic [CNT_W-1:0] IDX_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDX_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] IDX_THREE = CNT_W'(3);

`ifdef PHASE_SINGLE_STEP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP_WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [ICNT_W-1:0]  cnt_q, cnt_d;

  logic               running;
  logic [CNT_W-1:0]   lim_eff;
  logic               last_phase;
  logic [CNT_W-1:0]   lim_clamped;

  // Effective limit and clamped decode value; phases 1-2 always use the maximum
  // because decode has not produced a length yet.
  always_comb begin
    running     = (state_q == RUN);
    lim_eff     = (idx_q <= IDX_TWO) ? LIM_MAX : lim_q;
    last_phase  = (idx_q == lim_eff);
    lim_clamped = ((phase_limit < IDX_THREE) || (phase_limit > LIM_MAX)) ? LIM_MAX : phase_limit;
  end

  // State register; reset clears everything at once, mid-phase included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lim_q   <= LIM_MAX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: restart beats stall, completion wraps to phase 1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        idx_d   = IDX_ONE;
        lim_d   = LIM_MAX;
      end
      RUN: begin
        if (restart) begin
          // an aborted instruction only counts if it was already in its last phase
          idx_d = IDX_ONE;
          lim_d = LIM_MAX;
          if (last_phase) cnt_d = cnt_q + ICNT_W'(1);
        end else if (!stall) begin
          if (idx_q == IDX_TWO) lim_d = lim_clamped;
          if (last_phase) begin
            cnt_d = cnt_q + ICNT_W'(1);
            lim_d = LIM_MAX;
`ifdef PHASE_SINGLE_STEP_EN
            state_d = STEP_WAIT;
            idx_d   = '0;
`else
            idx_d   = IDX_ONE;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
`ifdef PHASE_SINGLE_STEP_EN
      STEP_WAIT: begin
        if (step || restart) begin
          state_d = RUN;
          idx_d   = IDX_ONE;
          lim_d   = LIM_MAX;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        lim_d   = LIM_MAX;
      end
    endcase
  end

  // Output decode; strobes are derived from the index so at most one bit is set.
  always_comb begin
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase[i] = running && (idx_q == CNT_W'(i + 1));
    end
    phase_idx   = running ? idx_q : '0;
    instr_start = running && (idx_q == IDX_ONE);
    instr_done  = running && last_phase;
    instr_count = cnt_q;
`ifdef PHASE_SINGLE_STEP_EN
    halted      = (state_q == STEP_WAIT);
`endif
  end

endmodule
